fpmul_pipe: RTL and testbench

- Parametrised, pipelined floating-point multiplier. Next generation of the single-channel binary32 fpmul.
- Adds configurable exponent/mantissa widths, configurable pipeline depth, valid/ready handshake with backpressure, a pass-through transaction tag and sticky exception flags.
- Sits between the operand sequencer and the result writeback. Rounding mode is carried per transaction.

---
 rtl/fpmul_pipe_if.sv | 31 +++
 rtl/fpmul_pipe.sv | 107 ++++++++++
 tb/tb_fpmul_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_pipe_if.sv
// fpmul_pipe_if: operand/result handshake bundle for fpmul_pipe
//   in_valid/in_ready, r_mode, fp_X, fp_Y, in_tag : operand channel
//   out_valid/out_ready, fp_Z, ovrf, udrf, out_tag : result channel
//   master = producer/consumer side, slave = multiplier side
interface fpmul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             r_mode;
    logic [EXP_W+MAN_W:0]   fp_X;
    logic [EXP_W+MAN_W:0]   fp_Y;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   fp_Z;
    logic                   ovrf;
    logic                   udrf;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output in_valid, r_mode, fp_X, fp_Y, in_tag, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf, out_tag
    );
    modport slave (
        input  in_valid, r_mode, fp_X, fp_Y, in_tag, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf, out_tag
    );
endinterface

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: parametrised pipelined FP multiplier, flush-to-zero, per-op rounding mode
//   clk, rstn (async, active-high)   : clock / reset
//   io (fpmul_pipe_if.slave)         : operand and result handshake channels
//   clr_sticky                       : synchronous clear of sticky flags
//   sticky_ovrf/udrf/inv             : accumulated exception flags
module fpmul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fpmul_pipe_if.slave io,
    input  logic        clr_sticky,
    output logic        sticky_ovrf,
    output logic        sticky_udrf,
    output logic        sticky_inv
);
    localparam int E  = EXP_W;
    localparam int M  = MAN_W;
    localparam int W  = 1 + E + M;
    localparam int PW = W + TAG_W + 4;
    localparam logic [E+1:0] BIAS = (E+2)'((1 << (E - 1)) - 1);

    logic sx, sy, s, xz, yz, xi, yi, nan, inf, zero, norm, g, stk, inc, cy;
    logic ovf_n, udf_n, to_inf, rtz, rdn, rup, rmm, adv, xfer, inv;
    logic [E-1:0] ex, ey;
    logic [M-1:0] mx, my, mant;
    logic [2*M+1:0] p, q;
    logic [M:0] sig;
    logic [M+1:0] sum;
    logic [E+1:0] e;
    logic [W-1:0] z;
    logic [PW-1:0] st0, last;
    logic [STAGES-1:0][PW-1:0] pl, nxt;

    assign {sx, ex, mx} = io.fp_X;
    assign {sy, ey, my} = io.fp_Y;

    // The whole result is formed before the first register; the remaining
    // stages only delay it, so results are independent of STAGES.
    always_comb begin
        rtz = io.r_mode == 3'd1;
        rdn = io.r_mode == 3'd2;
        rup = io.r_mode == 3'd3;
        rmm = io.r_mode == 3'd4;
        xz = ex == '0;
        yz = ey == '0;
        xi = &ex && mx == '0;
        yi = &ey && my == '0;
        nan = (&ex && mx != '0) || (&ey && my != '0) || (xi && yz) || (yi && xz);
        inf = (xi || yi) && !nan;
        zero = (xz || yz) && !nan && !inf;
        s = sx ^ sy;
        p = {{(M+1){1'b0}}, 1'b1, mx} * {{(M+1){1'b0}}, 1'b1, my};
        norm = p[2*M+1];
        q = norm ? p : p << 1;
        sig = q[2*M+1:M+1];
        g = q[M];
        stk = |q[M-1:0];
        inc = rtz ? 1'b0 : rdn ? s && (g || stk) : rup ? !s && (g || stk) : rmm ? g : g && (stk || sig[0]);
        sum = {1'b0, sig} + {{(M+1){1'b0}}, inc};
        cy = sum[M+1];
        mant = cy ? sum[M:1] : sum[M-1:0];
        e = {2'b0, ex} + {2'b0, ey} - BIAS + {{(E+1){1'b0}}, norm} + {{(E+1){1'b0}}, cy};
        ovf_n = !e[E+1] && (e[E] || &e[E-1:0]);
        udf_n = e[E+1] || e == '0;
        to_inf = !rtz && (rdn ? s : rup ? !s : 1'b1);
        z = nan ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} :
            inf ? {s, {E{1'b1}}, {M{1'b0}}} :
            (zero || udf_n) ? {s, {(W-1){1'b0}}} :
            ovf_n ? (to_inf ? {s, {E{1'b1}}, {M{1'b0}}} : {s, {(E-1){1'b1}}, 1'b0, {M{1'b1}}}) :
            {s, e[E-1:0], mant};
        st0 = {io.in_valid, nan, !nan && !inf && !zero && ovf_n,
               !nan && !inf && !zero && udf_n, io.in_tag, z};
    end

    if (STAGES == 1) begin : g_one
        assign nxt = st0;
    end else begin : g_shift
        assign nxt = {pl[STAGES-2:0], st0};
    end

    // Lock-step pipeline: a stall freezes every stage, bubbles included.
    always_ff @(posedge clk or posedge rstn)
        if (rstn) pl <= '0;
        else if (adv) pl <= nxt;

    assign last = pl[STAGES-1];
    assign {io.out_valid, inv, io.ovrf, io.udrf, io.out_tag, io.fp_Z} = last;
    assign adv = !(io.out_valid && !io.out_ready);
    assign io.in_ready = adv;
    assign xfer = io.out_valid && io.out_ready;

    // A flag raised on the same edge as a clear survives it.
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            sticky_ovrf <= 1'b0;
            sticky_udrf <= 1'b0;
            sticky_inv  <= 1'b0;
        end else begin
            sticky_ovrf <= (sticky_ovrf && !clr_sticky) || (xfer && io.ovrf);
            sticky_udrf <= (sticky_udrf && !clr_sticky) || (xfer && io.udrf);
            sticky_inv  <= (sticky_inv && !clr_sticky) || (xfer && inv);
        end
endmodule

// File: tb/tb_fpmul_pipe.sv
// tb_fpmul_pipe: directed vector table plus randomised stream against a reference model
module tb_fpmul_pipe;
    logic clk = 1'b0;
    logic rstn;
    logic clr;
    logic s_ov, s_ud, s_inv;
    int   passed = 0;
    int   total = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } vec_t;

    always #5 clk = ~clk;

    fpmul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fpmul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3), .TAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .io(bus), .clr_sticky(clr),
        .sticky_ovrf(s_ov), .sticky_udrf(s_ud), .sticky_inv(s_inv)
    );

    task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Reference: exact integer product, rounded by comparing the discarded
    // remainder with half an ulp. Returns {inv, ovf, udf, z}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        logic s;
        int ex, ey, e, k;
        longint p, qq, r, half;
        bit up, xn, yn, xi, yi, xz, yz, toinf;
        s = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xn = ex == 255 && x[22:0] != 0;
        yn = ey == 255 && y[22:0] != 0;
        xi = ex == 255 && x[22:0] == 0;
        yi = ey == 255 && y[22:0] == 0;
        xz = ex == 0;
        yz = ey == 0;
        if (xn || yn || (xi && yz) || (yi && xz)) return {3'b100, 32'h7FC00000};
        if (xi || yi) return {3'b000, s, 8'hFF, 23'h0};
        if (xz || yz) return {3'b000, s, 31'h0};
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        e = ex + ey - 127;
        k = 23;
        if (p >= (64'sd1 << 47)) begin
            k = 24;
            e++;
        end
        qq = p >> k;
        r = p - (qq << k);
        half = 64'sd1 << (k - 1);
        case (rm)
            3'd1: up = 0;
            3'd2: up = s && r != 0;
            3'd3: up = !s && r != 0;
            3'd4: up = r >= half;
            default: up = r > half || (r == half && qq[0]);
        endcase
        qq = qq + longint'(up);
        if (qq == (64'sd1 << 24)) begin
            qq = qq >> 1;
            e++;
        end
        if (e >= 255) begin
            toinf = rm == 3'd1 ? 0 : rm == 3'd2 ? s : rm == 3'd3 ? !s : 1;
            return toinf ? {3'b010, s, 8'hFF, 23'h0} : {3'b010, s, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], qq[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        logic [22:0] m;
        int k;
        k = $urandom_range(0, 9);
        e = k == 0 ? 8'd0 : k == 1 ? 8'hFF : k < 4 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(96, 158));
        m = (k == 1 && $urandom_range(0, 1) == 1) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                         input logic [3:0] tag, output logic [37:0] res, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fp_X = x;
        bus.fp_Y = y;
        bus.r_mode = rm;
        bus.in_tag = tag;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        res = {bus.ovrf, bus.udrf, bus.fp_Z, bus.out_tag};
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    // Random producer and stalling consumer; expected results queued at accept.
    task automatic stream(input int n, input int abort_at, output bit aborted);
        logic [38:0] q[$];
        logic [38:0] ex;
        logic [37:0] cur, held;
        logic [2:0]  acc;
        int sent, cyc;
        bit stall;
        sent = 0;
        cyc = 0;
        stall = 0;
        acc = 3'b000;
        held = '0;
        aborted = 0;
        while ((sent < n || q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cur = {bus.ovrf, bus.udrf, bus.fp_Z, bus.out_tag};
            if (stall) check("stall_hold", cur, held);
            if (abort_at >= 0 && cyc >= abort_at && bus.out_valid) begin
                #2 rstn = 1'b1;
                #1 check("async_rst_valid", bus.out_valid, 1'b0);
                bus.in_valid = 1'b0;
                aborted = 1;
                return;
            end
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.in_valid = sent < n && $urandom_range(0, 3) != 0;
            bus.fp_X = rnd_fp();
            bus.fp_Y = rnd_fp();
            bus.r_mode = 3'($urandom_range(0, 7));
            bus.in_tag = 4'(sent);
            #1;
            cur = {bus.ovrf, bus.udrf, bus.fp_Z, bus.out_tag};
            if (bus.out_valid && bus.out_ready) begin
                check("no_extra_result", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    ex = q.pop_front();
                    check("stream_result", cur, ex[37:0]);
                    acc = acc | {ex[37], ex[36], ex[38]};
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            held = cur;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({model(bus.fp_X, bus.fp_Y, bus.r_mode), bus.in_tag});
                sent++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_sent", sent, n);
        check("stream_drained", q.size(), 0);
        @(posedge clk);
        #1 check("stream_sticky", {s_ov, s_ud, s_inv}, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[20];
        logic [37:0] res;
        int lat;
        bit ab;
        vt[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0};
        vt[1]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0};
        vt[3]  = '{32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 1'b0, 1'b0};
        vt[4]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0};
        vt[5]  = '{32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 1'b0, 1'b0};
        vt[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 1'b1, 1'b0};
        vt[7]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0};
        vt[8]  = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0};
        vt[9]  = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 1'b1, 1'b0};
        vt[10] = '{32'h7F7FFFFF, 32'h40000000, 3'd6, 32'h7F800000, 1'b1, 1'b0};
        vt[11] = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 1'b0, 1'b1};
        vt[12] = '{32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 1'b0, 1'b1};
        vt[13] = '{32'h00000000, 32'h3F800000, 3'd0, 32'h00000000, 1'b0, 1'b0};
        vt[14] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
        vt[15] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 1'b0, 1'b0};
        vt[16] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 1'b0, 1'b0};
        vt[17] = '{32'h3F800003, 32'h3FC00000, 3'd5, 32'h3FC00004, 1'b0, 1'b0};
        vt[18] = '{32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001, 1'b0, 1'b0};
        vt[19] = '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 1'b0, 1'b0};

        rstn = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.fp_X = '0;
        bus.fp_Y = '0;
        bus.r_mode = '0;
        bus.in_tag = '0;
        #23;
        check("rst_outputs", {bus.out_valid, bus.fp_Z, bus.ovrf, bus.udrf, bus.out_tag}, '0);
        check("rst_sticky", {s_ov, s_ud, s_inv}, 3'b000);
        @(negedge clk) rstn = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", bus.in_ready, 1'b1);

        for (int i = 0; i < 20; i++) begin
            do_op(vt[i].x, vt[i].y, vt[i].rm, 4'(i), res, lat);
            check($sformatf("vec%0d", i), res, {vt[i].ov, vt[i].ud, vt[i].z, 4'(i)});
            check($sformatf("lat%0d", i), lat, 3);
        end
        check("sticky_accum", {s_ov, s_ud, s_inv}, 3'b111);
        pulse_clr();
        #1 check("sticky_clr", {s_ov, s_ud, s_inv}, 3'b000);

        do_op(32'h7FC00000, 32'h3F800000, 3'd0, 4'hA, res, lat);
        check("nan_prop", res, {2'b00, 32'h7FC00000, 4'hA});
        check("sticky_inv", {s_ov, s_ud, s_inv}, 3'b001);
        @(negedge clk) clr = 1'b1;
        do_op(32'h7F7FFFFF, 32'h40000000, 3'd0, 4'h5, res, lat);
        check("set_wins_clr", {s_ov, s_ud, s_inv}, 3'b100);
        clr = 1'b0;

        pulse_clr();
        stream(16, -1, ab);
        pulse_clr();
        stream(300, -1, ab);
        pulse_clr();
        stream(40, 10, ab);
        check("rst_hit", ab, 1'b1);
        check("rst_mid_outputs", {bus.out_valid, bus.fp_Z, bus.ovrf, bus.udrf, bus.out_tag, s_ov, s_ud, s_inv}, '0);
        @(negedge clk) rstn = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("ready_after_mid_rst", bus.in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 check("no_stale", bus.out_valid, 1'b0);
        end
        do_op(32'h3FC00000, 32'h40000000, 3'd0, 4'h3, res, lat);
        check("post_rst_op", res, {2'b00, 32'h40400000, 4'h3});
        check("post_rst_lat", lat, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
